// File: rtl/conv_sched_pkg.sv
// Shared types, sizing constants and the operand-memory address helper
// for the convolution feed scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int N_LANES       = 3;
    localparam int N_WIN         = 4;
    localparam int LOAD_CYCLES   = 3;
    localparam int STREAM_CYCLES = 14;
    localparam int A_DIM         = 4;

    function automatic logic [4:0] elem_addr(input logic       sel_b,
                                             input logic [1:0] row,
                                             input logic [1:0] col);
        return {sel_b, 4'(A_DIM * int'(row) + int'(col))};
    endfunction

endpackage

// File: rtl/conv_lane_addr_gen.sv
// One systolic lane: derives operand valid and memory address from the
// scheduler state and step counter, with the lane's skew of LANE cycles.
module conv_lane_addr_gen
    import conv_sched_pkg::*;
#(
    parameter int LANE = 0
)
(
    input  state_t     state,
    input  logic [3:0] t,
    output logic       valid,
    output logic [4:0] addr
);

    logic [3:0] step;
    logic [1:0] win;
    logic [1:0] col_ofs;

    always_comb begin
        valid   = 1'b0;
        addr    = 5'd0;
        step    = t - 4'(LANE);
        win     = 2'(step / 4'd3);
        col_ofs = 2'(step % 4'd3);
        case (state)
            LOAD_W: begin
                valid = 1'b1;
                addr  = elem_addr(1'b1, 2'(LANE), t[1:0]);
            end
            STREAM: begin
                // t < LANE wraps step to 14..15, so one bound covers both ends
                if (step <= 4'd11) begin
                    valid = 1'b1;
                    addr  = elem_addr(1'b0, 2'(LANE) + {1'b0, win[1]},
                                      {1'b0, win[0]} + col_ofs);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/conv_feed_scheduler.sv
// Job sequencer for the convolution operand memory: loads the 3x3 filter,
// streams four skewed input windows and strobes each drained result.
//
// state  | meaning
// IDLE   | waiting for start; stall ignored
// LOAD_W | t=0..2, filter column t presented on all lanes
// STREAM | t=0..13, skewed window operands on lanes 0..2
// DRAIN  | t=0..DRAIN_LAT-1, waiting for the last result
// DONE   | single-cycle completion pulse
module conv_feed_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DRAIN_LAT = 3
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic [4:0] address1,
    output logic [4:0] address2,
    output logic [4:0] address3,
    output logic [2:0] lane_valid,
    output logic       load_weight,
    output logic       out_valid,
    output logic [1:0] out_win,
    output logic       busy,
    output logic       done
);

    state_t                     state, state_next;
    logic [3:0]                 t, t_next;
    logic [N_LANES-1:0]         lane_raw;
    logic [4:0]                 lane_addr [N_LANES];
    logic                       push;
    logic [1:0]                 push_win;
    logic [DRAIN_LAT-1:0]       res_v;
    logic [DRAIN_LAT-1:0][1:0]  res_w;
    logic                       frozen;

    assign busy   = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
    assign frozen = busy && stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            t     <= 4'd0;
        end else begin
            state <= state_next;
            t     <= t_next;
        end
    end

    always_comb begin
        state_next = state;
        t_next     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_W;
                    t_next     = 4'd0;
                end
            end
            LOAD_W: begin
                if (!stall) begin
                    if (t == 4'(LOAD_CYCLES - 1)) begin
                        state_next = STREAM;
                        t_next     = 4'd0;
                    end else begin
                        t_next = t + 4'd1;
                    end
                end
            end
            STREAM: begin
                if (!stall) begin
                    if (t == 4'(STREAM_CYCLES - 1)) begin
                        state_next = DRAIN;
                        t_next     = 4'd0;
                    end else begin
                        t_next = t + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (t == 4'(DRAIN_LAT - 1)) begin
                        state_next = DONE;
                        t_next     = 4'd0;
                    end else begin
                        t_next = t + 4'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                t_next     = 4'd0;
            end
            default: begin
                state_next = IDLE;
                t_next     = 4'd0;
            end
        endcase
    end

    // Lane 2 issues the final operand of window w at STREAM t=3w+4
    always_comb begin
        push     = 1'b0;
        push_win = 2'd0;
        if (state == STREAM) begin
            case (t)
                4'd4:    begin push = 1'b1; push_win = 2'd0; end
                4'd7:    begin push = 1'b1; push_win = 2'd1; end
                4'd10:   begin push = 1'b1; push_win = 2'd2; end
                4'd13:   begin push = 1'b1; push_win = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_v <= '0;
            res_w <= '0;
        end else if (!frozen) begin
            res_v[0] <= push;
            res_w[0] <= push_win;
            for (int i = 1; i < DRAIN_LAT; i++) begin
                res_v[i] <= res_v[i-1];
                res_w[i] <= res_w[i-1];
            end
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        conv_lane_addr_gen #(.LANE(k)) u_lane (
            .state (state),
            .t     (t),
            .valid (lane_raw[k]),
            .addr  (lane_addr[k])
        );
    end

    assign address1    = lane_addr[0];
    assign address2    = lane_addr[1];
    assign address3    = lane_addr[2];
    assign lane_valid  = lane_raw & {N_LANES{~stall}};
    assign load_weight = (state == LOAD_W) && !stall;
    assign out_valid   = res_v[DRAIN_LAT-1] && !stall;
    assign out_win     = res_v[DRAIN_LAT-1] ? res_w[DRAIN_LAT-1] : 2'd0;
    assign done        = (state == DONE);

endmodule

// File: doc/conv_feed_scheduler.md
# conv_feed_scheduler

- Sequences the three read ports of the convolution operand memory, which holds a 4x4 input A and a 3x3 filter B.
- Per job:
  - loads the filter into a 3-lane systolic array;
  - streams the four 3x3 input windows with per-lane skew;
  - flags each finished 2x2 output result after the array pipeline drains.
- Sits between the top-level job control (start/stall) and the memory's `address1..3` inputs.

## Interface
- `DRAIN_LAT`, default 3: array pipeline depth in cycles from the last operand issue of a window to its result. Legal range is 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE only.
- `stall` in 1: freezes sequencing while high.
- `address1` / `address2` / `address3` out 5: read address for lane 0/1/2.
  - Bit 4 selects B (1) or A (0).
  - Bits 3:0 are the element index, 4*row+col, 0-based.
- `lane_valid` out 3: bit k means address(k+1) carries a live operand this cycle.
- `load_weight` out 1: lanes carry filter values (array latches weights).
- `out_valid` out 1: one-cycle strobe when a window result is complete.
- `out_win` out 2: window index for `out_valid`. Window w covers r=w>>1, c=w&1.
- `busy` out 1: high in LOAD_W, STREAM and DRAIN.
- `done` out 1: one-cycle pulse in DONE.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE. Step counter `t` is cleared on every state entry.
- **IDLE:**
  - `start`=1 at an edge moves to LOAD_W.
  - `stall` is ignored, including when `start` and `stall` are both high.
- **LOAD_W, t=0..2 (filter column j=t):**
  - all lanes valid, `load_weight`=1;
  - lane k address = {1, 4*k+j}.
  - Then go to STREAM.
- **STREAM, t=0..13:**
  - Base step s=0..11 gives w=s/3, j=s%3.
  - Lane k issues step s at t=s+k. It is valid iff 0<=t-k<=11.
  - Address = {0, 4*(r+k)+c+j}.
  - After t=13, go to DRAIN.
- **Result tracking:**
  - Window w's last operand issues at STREAM t=3w+4.
  - `out_valid`=1 with `out_win`=w exactly DRAIN_LAT unstalled cycles later.
  - Results may overlap with STREAM.
- **DRAIN:** lasts DRAIN_LAT cycles, covering STREAM t=14..13+DRAIN_LAT. Window 3's strobe lands on its last cycle. Then go to DONE.
- **DONE:** one cycle, `done`=1, `busy`=0. Then go to IDLE.
- `start` outside IDLE is ignored. There is no queuing.
- **Stall** (LOAD_W, STREAM, DRAIN only):
  - state, `t` and the result-tracking pipeline hold;
  - `lane_valid`, `load_weight` and `out_valid` are forced 0 combinationally;
  - addresses hold their values.
- **Invalid lanes** drive address 5'd0.

## Timing
- **Reset** (async assert, any state): state goes to IDLE, the tracking pipeline clears, and all outputs are 0. This includes mid-job; the aborted job produces no further strobes.
- **Unstalled job**, with `start` sampled at edge 0 and periods numbered after edge 0:
  - LOAD_W: periods 0-2.
  - STREAM: periods 3-16.
  - DRAIN: 17..16+DRAIN_LAT.
  - DONE: 17+DRAIN_LAT.
  - With the default: `out_valid` at periods 10, 13, 16 and 19 (w=0..3), DONE at period 20.
- **Output paths:**
  - All outputs except the stall-gated valids decode from registered state only.
  - The only input-to-output path is `stall` into `lane_valid`, `load_weight` and `out_valid`.
- **Back-to-back jobs:** `start` held high through DONE launches the next job at the edge after DONE (IDLE is visible for 1 period).

## Structure
- Package `conv_sched_pkg`:
  - state enum;
  - constants `N_LANES`=3, `N_WIN`=4, `LOAD_CYCLES`=3, `STREAM_CYCLES`=14, `A_DIM`=4;
  - function `elem_addr(sel_b, row, col)` returning {sel_b, 4*row+col}.
- Sub-module `conv_lane_addr_gen`, parameter `LANE`: maps state and `t` to that lane's valid and address. Instantiated 3 times.
- Top level holds the FSM, counter, and DRAIN_LAT-deep result shift register (valid + 2-bit window).

## Test plan
- **Reset, then `start`=1:**
  - LOAD_W t=1 gives addresses 17/21/25 with `lane_valid`=3'b111.
  - STREAM t=0 gives `lane_valid`=3'b001, address1=0.
  - t=2 gives 3'b111 with address3=8.
- **Full job, default `DRAIN_LAT`:**
  - STREAM t=13 gives `lane_valid`=3'b100, address3=15.
  - `out_valid` at periods 10/13/16/19 with `out_win` 0/1/2/3.
  - `done` at period 20 only.
  - Every issued address matches a golden model: 36 A reads per lane set, 9 B reads.
- **Stall:**
  - `stall` high for 5 cycles at STREAM t=6: valids are 0, addresses hold.
  - Sequence resumes at t=6.
  - All later strobes and `done` shift by exactly 5.
- **Ignored start:** `start` pulsed during STREAM and during DONE is ignored; exactly one `done` results.
- **Reset mid-job:** `rst` low at STREAM t=5 gives immediate all-zero outputs and no `out_valid` afterward. A fresh `start` then runs a full correct job.
- **`DRAIN_LAT`=1:** `out_valid` at periods 8/11/14/17 and `done` at period 18.
